// File: rtl/au_cmp_mag_seq_pkg.sv
// ---------------------------------------------------------------------------
// au_cmp_pkg
//
// Shared types and helpers for the multi-cycle magnitude comparator.
//   state_t   : scan FSM state (IDLE, CMP)
//   clog2     : ceiling log2 of a positive integer (0 for n <= 1)
//   idx_width : width of the chunk index, never narrower than one bit
// ---------------------------------------------------------------------------
package au_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single-chunk comparator still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage : au_cmp_pkg

// File: rtl/au_cmp_mag_seq_if.sv
// ---------------------------------------------------------------------------
// au_cmp_mag_seq_if
//
// Request/result bundle of the multi-cycle magnitude comparator.
//   start      : request, honoured only while busy = 0
//   a, b       : WIDTH*NCHUNK-bit operands, captured with an accepted start
//   busy       : comparison in progress
//   done       : one-cycle pulse, result valid from this cycle on
//   lt, eq, gt : registered result, one-hot after the first done
// Modports: master drives the request, slave is the comparator.
// ---------------------------------------------------------------------------
interface au_cmp_mag_seq_if #(
  parameter int WIDTH  = 8,
  parameter int NCHUNK = 4
);

  localparam int W = WIDTH * NCHUNK;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         lt;
  logic         eq;
  logic         gt;

  modport master (
    output start, a, b,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, a, b,
    output busy, done, lt, eq, gt
  );

endinterface : au_cmp_mag_seq_if

// File: rtl/au_cmp_mag_seq_chunk.sv
// ---------------------------------------------------------------------------
// au_cmp_chunk
//
// Combinational WIDTH-bit chunk comparator.
//   x, y : chunk operands
//   sgn  : 1 = invert the MSB of both operands before comparing, which turns
//          an unsigned compare into a two's-complement compare of the
//          sign-carrying chunk
//   c_lt : x < y
//   c_eq : x == y
// ---------------------------------------------------------------------------
module au_cmp_chunk #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sgn,
  output logic             c_lt,
  output logic             c_eq
);

  logic [WIDTH-1:0] msb_mask;
  logic [WIDTH-1:0] x_m;
  logic [WIDTH-1:0] y_m;

  // Built bit-wise so that WIDTH = 1 needs no zero-width replication.
  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so
    // no path through the block leaves it unassigned (which would be a latch).
    msb_mask            = '0;
    msb_mask[WIDTH-1]   = sgn;
  end

  assign x_m  = x ^ msb_mask;
  assign y_m  = y ^ msb_mask;
  assign c_lt = (x_m < y_m);
  assign c_eq = (x_m == y_m);

endmodule : au_cmp_chunk

// File: rtl/au_cmp_mag_seq.sv
// ---------------------------------------------------------------------------
// au_cmp_mag_seq
//
// Multi-cycle magnitude/equality comparator for WIDTH*NCHUNK-bit operands.
// Scans one WIDTH-bit chunk per cycle, most-significant chunk first, and
// finishes at the first differing chunk (or after chunk 0 when all match).
//
// Parameters:
//   WIDTH  : chunk width in bits (>= 1)
//   NCHUNK : chunks per operand (>= 1)
//   TC     : 0 = unsigned compare, 1 = two's-complement compare
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, aborts any operation
//   bus    : au_cmp_mag_seq_if slave (start/a/b in, busy/done/lt/eq/gt out)
// All outputs are registers.
// ---------------------------------------------------------------------------
module au_cmp_mag_seq
  import au_cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCHUNK = 4,
  parameter int TC     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  au_cmp_mag_seq_if.slave   bus
);

  localparam int W  = WIDTH * NCHUNK;
  localparam int IW = idx_width(NCHUNK);
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  // Elaboration-time parameter sanity check.
  if (WIDTH < 1) begin : g_bad_width
    $error("au_cmp_mag_seq: WIDTH must be >= 1 (got %0d)", WIDTH);
  end
  if (NCHUNK < 1) begin : g_bad_nchunk
    $error("au_cmp_mag_seq: NCHUNK must be >= 1 (got %0d)", NCHUNK);
  end

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            busy_q;
  logic            done_q;
  logic            lt_q;
  logic            eq_q;
  logic            gt_q;

  logic            accept;
  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] y_c;
  logic            sgn_c;
  logic            c_lt;
  logic            c_eq;
  logic            last;

  assign accept = (state == IDLE) && bus.start;

  // Operand capture. These registers only carry data that is consumed after
  // a capture, so they need no reset value.
  // NOTE: datapath storage that is always written before it is read is left
  // out of the reset; only control state and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  // Chunk mux: select chunk idx of both captured operands.
  always_comb begin
    x_c = '0;
    y_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        x_c = a_q[i*WIDTH +: WIDTH];
        y_c = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the top chunk holds the sign bit.
  assign sgn_c = (TC != 0) && (idx == IDX_TOP);

  au_cmp_chunk #(
    .WIDTH (WIDTH)
  ) u_chunk (
    .x    (x_c),
    .y    (y_c),
    .sgn  (sgn_c),
    .c_lt (c_lt),
    .c_eq (c_eq)
  );

  // The scan ends on the first mismatching chunk or after the lowest one.
  assign last = !c_eq || (idx == '0);

  // FSM, index counter and result registers.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            idx    <= IDX_TOP;
            busy_q <= 1'b1;
            state  <= CMP;
          end
        end
        CMP: begin
          if (last) begin
            lt_q   <= c_lt;
            eq_q   <= c_eq;
            gt_q   <= !c_lt && !c_eq;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;

endmodule : au_cmp_mag_seq

// File: tb/tb_au_cmp_mag_seq.sv
// ---------------------------------------------------------------------------
// tb_au_cmp_mag_seq
//
// Directed bench for au_cmp_mag_seq with WIDTH = 8, NCHUNK = 4. Two
// instances receive identical stimulus: dut0 with TC = 0 (unsigned) and
// dut1 with TC = 1 (two's complement). Inputs change on the falling edge,
// outputs are sampled on the falling edge. Results are packed {lt,eq,gt}.
// ---------------------------------------------------------------------------
module tb_au_cmp_mag_seq;

  localparam int WIDTH  = 8;
  localparam int NCHUNK = 4;
  localparam int MAXLAT = 20;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;

  au_cmp_mag_seq_if #(.WIDTH(WIDTH), .NCHUNK(NCHUNK)) if0 ();
  au_cmp_mag_seq_if #(.WIDTH(WIDTH), .NCHUNK(NCHUNK)) if1 ();

  au_cmp_mag_seq #(.WIDTH(WIDTH), .NCHUNK(NCHUNK), .TC(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  au_cmp_mag_seq #(.WIDTH(WIDTH), .NCHUNK(NCHUNK), .TC(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] res0();
    return {if0.lt, if0.eq, if0.gt};
  endfunction

  function automatic logic [2:0] res1();
    return {if1.lt, if1.eq, if1.gt};
  endfunction

  function automatic logic [4:0] outs0();
    return {if0.busy, if0.done, if0.lt, if0.eq, if0.gt};
  endfunction

  function automatic logic [4:0] outs1();
    return {if1.busy, if1.done, if1.lt, if1.eq, if1.gt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] av,
                       input logic [31:0] bv);
    if0.start = s; if0.a = av; if0.b = bv;
    if1.start = s; if1.a = av; if1.b = bv;
  endtask

  // Continue counting falling edges from lat0 until dut0 reports done.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if0.done && lat < MAXLAT);
  endtask

  // One complete operation: start for one cycle, then latency/result checks
  // for both instances and a check that done lasts exactly one cycle.
  task automatic do_op(input string tag, input logic [31:0] av,
                       input logic [31:0] bv, input int exp_lat,
                       input logic [2:0] exp0, input logic [2:0] exp1);
    int lat;
    @(negedge clk);
    drive(1'b1, av, bv);
    @(negedge clk);
    drive(1'b0, av, bv);
    check({tag, "_busy"}, {31'd0, if0.busy & if1.busy}, 32'd1);
    wait_done(0, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_done1"}, {31'd0, if1.done}, 32'd1);
    check({tag, "_res0"}, {29'd0, res0()}, {29'd0, exp0});
    check({tag, "_res1"}, {29'd0, res1()}, {29'd0, exp1});
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, if0.done, if1.done}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  stray;
    bit  stable;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outs0", {27'd0, outs0()}, 32'd0);
    check("reset_outs1", {27'd0, outs1()}, 32'd0);
    rst_n = 1'b1;

    // Equal operands: full scan of 4 chunks.
    do_op("equal", 32'h1234_5678, 32'h1234_5678, 4, R_EQ, R_EQ);

    // Top chunk differs: 0x80 vs 0x7F; signed sees -128 vs 127.
    do_op("top_diff", 32'h8000_0000, 32'h7FFF_FFFF, 1, R_GT, R_LT);

    // Only the lowest chunk differs.
    do_op("low_diff", 32'h0000_0001, 32'h0000_0002, 4, R_LT, R_LT);

    // Most negative vs +1.
    do_op("signed", 32'h8000_0000, 32'h0000_0001, 1, R_GT, R_LT);

    // Start while busy is ignored; operands changed mid-operation unused.
    // Captured 3 vs 5 is lt after 4 chunks; the intruder would be fast gt.
    @(negedge clk);
    drive(1'b1, 32'h0000_0003, 32'h0000_0005);
    @(negedge clk);
    drive(1'b0, 32'h0000_0003, 32'h0000_0005);
    @(negedge clk);
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);
    drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_done(2, lat);
    check("ignore_lat", lat, 4);
    check("ignore_res0", {29'd0, res0()}, {29'd0, R_LT});
    check("ignore_res1", {29'd0, res1()}, {29'd0, R_LT});
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if0.done || if0.busy || if1.done || if1.busy) stray = 1'b1;
    end
    check("ignore_no_second_op", {31'd0, stray}, 32'd0);

    // start held high across done: second request accepted at the edge
    // after done, results stable until the second done.
    @(negedge clk);
    drive(1'b1, 32'h0003_0000, 32'h0002_0000);
    @(negedge clk);
    check("b2b_busy1", {31'd0, if0.busy}, 32'd1);
    wait_done(0, lat);
    check("b2b_lat1", lat, 2);
    check("b2b_res1", {29'd0, res0()}, {29'd0, R_GT});
    drive(1'b1, 32'hAABB_CCDD, 32'hAABB_CCDD);
    @(negedge clk);
    check("b2b_accept", {30'd0, if0.busy, if1.busy}, 32'd3);
    drive(1'b0, 32'hAABB_CCDD, 32'hAABB_CCDD);
    lat    = 0;
    stable = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!if0.done && res0() != R_GT) stable = 1'b0;
    end while (!if0.done && lat < MAXLAT);
    check("b2b_lat2", lat, 4);
    check("b2b_stable", {31'd0, stable}, 32'd1);
    check("b2b_res2_0", {29'd0, res0()}, {29'd0, R_EQ});
    check("b2b_res2_1", {29'd0, res1()}, {29'd0, R_EQ});

    // Asynchronous reset two cycles into a 4-chunk compare.
    @(negedge clk);
    drive(1'b1, 32'h0000_0000, 32'h0000_0000);
    @(negedge clk);
    drive(1'b0, 32'h0000_0000, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs0", {27'd0, outs0()}, 32'd0);
    check("async_rst_outs1", {27'd0, outs1()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if0.done || if1.done || if0.busy || if1.busy) stray = 1'b1;
    end
    check("rst_no_done", {31'd0, stray}, 32'd0);

    // Normal operation after the aborted one.
    do_op("post_rst", 32'h0000_0010, 32'h0000_0020, 4, R_LT, R_LT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_au_cmp_mag_seq

// File: doc/au_cmp_mag_seq.md
# au_cmp_mag_seq

Multi-cycle magnitude and equality comparator for wide operands. It scans the operands one WIDTH-bit chunk per cycle, most-significant chunk first, and stops at the first chunk that differs. Results are registered with a start/done handshake. It sits beside the single-cycle comparators in the arithmetic-unit library and is used where operand width makes a flat comparator too slow for the target clock.

## Interface
- WIDTH, 8: chunk width in bits (>= 1).
- NCHUNK, 4: number of chunks per operand (>= 1). Operand width is W = WIDTH*NCHUNK.
- TC, 0: 0 = unsigned compare; 1 = two's-complement compare of the full W-bit operands.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy = 0.
- a  in  W  operand A; sampled only on an accepted start.
- b  in  W  operand B; sampled only on an accepted start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse; the result is valid from this cycle on.
- lt  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.

## Operation
- Two states:
  - IDLE: busy = 0. An accepted start captures a and b into registers, sets idx = NCHUNK-1, and moves to CMP.
  - CMP: busy = 1. Each cycle compares chunk idx of the captured operands.
    - Chunks differ, or idx == 0: register lt/eq/gt, pulse done, return to IDLE.
    - Otherwise: decrement idx and stay in CMP.
- Chunk compare is unsigned, except when TC = 1 and idx = NCHUNK-1: the MSB of both chunks is inverted before comparing (sign handling).
- Result encoding: exactly one of lt/eq/gt is 1 after any done. eq = 1 only if all NCHUNK chunks match.
- lt/eq/gt hold their value from a done until the next done. They do not change on start.
- start while busy = 1 is ignored. Operand changes while busy have no effect.
- Reset, at any time including mid-CMP, forces IDLE and aborts the operation.
- Reset values: busy = 0, done = 0, lt = 0, eq = 0, gt = 0, idx = 0.
- NCHUNK = 1 degenerates to a one-cycle registered compare.

## Timing
- Edge E0: start accepted (busy was 0). busy = 1 after E0.
- Edge Ek (k >= 1) evaluates chunk NCHUNK-k.
- Completing at Ej: done = 1, busy = 0, and lt/eq/gt updated, all in the cycle after Ej.
- Latency from start edge to done is j cycles, with 1 <= j <= NCHUNK. j is the index of the first differing chunk counted from the MSB side; j = NCHUNK for equal operands.
- done lasts exactly one cycle.
- A start held high during the done cycle is accepted at the next edge. Back-to-back operations therefore have no bubble beyond the done cycle.
- No combinational path from inputs to outputs; all outputs are registers.

## Structure
- Shared package au_cmp_pkg:
  - state enum {IDLE, CMP};
  - function clog2 for the idx width, which is max(1, clog2(NCHUNK)).
- One sub-module: au_cmp_chunk.
  - Combinational, WIDTH-bit.
  - Inputs: x, y, and sgn (invert MSB when 1).
  - Outputs: c_lt, c_eq.
  - Instantiated once on the muxed chunk selected by idx.
- Top level contains: FSM, idx counter, operand registers, and result registers.
- Parameter check in simulation: WIDTH < 1 or NCHUNK < 1 prints an error and terminates.

## Test plan
All scenarios use WIDTH = 8 and NCHUNK = 4 unless stated.
- Equal operands: TC = 0, a = b = 0x12345678, start one cycle → done 4 cycles after the start edge; eq = 1, lt = 0, gt = 0.
- Early exit, unsigned: TC = 0, a = 0x80000000, b = 0x7FFFFFFF → done after 1 cycle, gt = 1.
- Early exit, low chunk: TC = 0, a = 0x00000001, b = 0x00000002 → done after 4 cycles, lt = 1.
- Signed: TC = 1, a = 0x80000000 (most negative), b = 0x00000001 → done after 1 cycle, lt = 1. The same operands with TC = 0 give gt = 1.
- Handshake:
  - A start during busy is ignored, and operands changed mid-operation are not used.
  - start held high across done → the second operation is accepted at the edge after done, with no lost request.
  - lt/eq/gt stay stable between the two dones.
- Reset: rst_n = 0 two cycles into a 4-chunk compare → all outputs 0 immediately (asynchronous). No done follows. The next start after release completes normally.
